// File: rtl/axi_ic_pkg.sv
// Shared definitions for the AXI interconnect arbiters.
//   ARB_RR / ARB_FIXED : encodings of the arbiter_type input
//   aw_state_e / ar_state_e : address-channel grant FSM states
//   clog2 : ceiling log2, used for index and FIFO pointer widths
package axi_ic_pkg;

  localparam logic ARB_RR    = 1'b0;
  localparam logic ARB_FIXED = 1'b1;

  typedef enum logic {AW_RUN = 1'b0, AW_WAIT = 1'b1} aw_state_e;
  typedef enum logic {AR_RUN = 1'b0, AR_WAIT = 1'b1} ar_state_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_arb_core.sv
// Combinational one-hot selector with a round-robin pointer.
//   clk, rst_n   : clock, asynchronous active-low reset
//   arb_type     : ARB_RR searches from the pointer, ARB_FIXED from index 0
//   req          : request vector, one bit per master
//   accept       : strobe, the grant on accept_grant completed a handshake
//   accept_grant : one-hot grant that was accepted (moves the pointer past it)
//   sel          : one-hot selection of req (0 when no request)
module axi_arb_core
  import axi_ic_pkg::*;
#(
  parameter int NUM = 3,
  localparam int IW = (clog2(NUM + 1) < 1) ? 1 : clog2(NUM + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           arb_type,
  input  logic [NUM:0]   req,
  input  logic           accept,
  input  logic [NUM:0]   accept_grant,
  output logic [NUM:0]   sel
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] ptr_nxt;
  logic [IW-1:0] acc_idx;
  logic          found;
  int            start;

  // Two passes: indices at/after the start point first, then the wrap-around.
  // Fixed priority is the same search with the start point pinned at 0.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    start = (arb_type == ARB_FIXED) ? 0 : int'(ptr);
    for (int i = 0; i <= NUM; i++) begin
      if (!found && req[i] && (i >= start)) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int i = 0; i <= NUM; i++) begin
      if (!found && req[i] && (i < start)) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    acc_idx = '0;
    for (int i = 0; i <= NUM; i++) begin
      if (accept_grant[i]) acc_idx = IW'(i);
    end
    ptr_nxt = (acc_idx == IW'(NUM)) ? '0 : acc_idx + IW'(1);
  end

  // The pointer tracks handshakes in both modes so a mode switch starts clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/axi_arbiter_m2s_wlock.sv
// Master-to-slave arbiter for one slave port: AW and AR grants among NUM+1
// masters, plus an AW-order FIFO that locks W data to AW acceptance order.
//   AXI_CLK, AXI_RSTn       : clock, asynchronous active-low reset
//   arbiter_type            : 0 round-robin, 1 fixed priority (lowest index)
//   AWSELECT/AWVALID/AWREADY: per-master AW request and slave ready
//   AWGRANT                 : one-hot AW grant (or 0)
//   WVALID/WREADY/WLAST     : per-master W beat signals
//   WGRANT                  : one-hot W grant = FIFO head (or 0)
//   ARSELECT/ARVALID/ARREADY: per-master AR request and slave ready
//   ARGRANT                 : one-hot AR grant (or 0)
//   wfifo_full, wfifo_level : AW-order FIFO status
//   aw_state_dbg, ar_state_dbg : grant FSM states
//
// Handshake rule for every channel: a transfer happens in the cycle where
// grant, VALID and READY are all high for the same master; a grant given to
// a VALID master is held unchanged until that transfer happens.
module axi_arbiter_m2s_wlock
  import axi_ic_pkg::*;
#(
  parameter int NUM         = 3,
  parameter int WFIFO_DEPTH = 4,
  localparam int IW = (clog2(NUM + 1) < 1) ? 1 : clog2(NUM + 1),
  localparam int LW = clog2(WFIFO_DEPTH)
) (
  input  logic          AXI_CLK,
  input  logic          AXI_RSTn,
  input  logic          arbiter_type,
  input  logic [NUM:0]  AWSELECT,
  input  logic [NUM:0]  AWVALID,
  input  logic [NUM:0]  AWREADY,
  output logic [NUM:0]  AWGRANT,
  input  logic [NUM:0]  WVALID,
  input  logic [NUM:0]  WREADY,
  input  logic [NUM:0]  WLAST,
  output logic [NUM:0]  WGRANT,
  input  logic [NUM:0]  ARSELECT,
  input  logic [NUM:0]  ARVALID,
  input  logic [NUM:0]  ARREADY,
  output logic [NUM:0]  ARGRANT,
  output logic          wfifo_full,
  output logic [LW:0]   wfifo_level,
  output aw_state_e     aw_state_dbg,
  output ar_state_e     ar_state_dbg
);

  logic [NUM:0] awreq, arreq;
  logic [NUM:0] aw_sel, ar_sel;
  logic [NUM:0] aw_hold, aw_hold_nxt, ar_hold, ar_hold_nxt;
  logic         hs_aw, hs_ar, w_pop;
  aw_state_e    aw_state, aw_state_nxt;
  ar_state_e    ar_state, ar_state_nxt;

  logic [IW-1:0] wf_mem [WFIFO_DEPTH];
  logic [LW:0]   wr_ptr, rd_ptr;
  logic [IW-1:0] aw_idx;
  logic [IW-1:0] wf_head;
  logic          wfifo_empty;

  assign awreq = AWSELECT & AWVALID;
  assign arreq = ARSELECT & ARVALID;

  axi_arb_core #(.NUM(NUM)) u_aw_core (
    .clk          (AXI_CLK),
    .rst_n        (AXI_RSTn),
    .arb_type     (arbiter_type),
    .req          (awreq),
    .accept       (hs_aw),
    .accept_grant (AWGRANT),
    .sel          (aw_sel)
  );

  axi_arb_core #(.NUM(NUM)) u_ar_core (
    .clk          (AXI_CLK),
    .rst_n        (AXI_RSTn),
    .arb_type     (arbiter_type),
    .req          (arreq),
    .accept       (hs_ar),
    .accept_grant (ARGRANT),
    .sel          (ar_sel)
  );

  // ---------------- AW channel ----------------
  // A full FIFO blocks new AW grants; a grant already held in AW_WAIT was
  // issued with room left, and only this channel pushes, so it still fits.
  always_comb begin
    AWGRANT = '0;
    if (AXI_RSTn) begin
      case (aw_state)
        AW_RUN:  AWGRANT = wfifo_full ? '0 : aw_sel;
        AW_WAIT: AWGRANT = aw_hold;
        default: AWGRANT = '0;
      endcase
    end
  end

  assign hs_aw = |(AWGRANT & AWVALID & AWREADY);

  always_comb begin
    aw_state_nxt = aw_state;
    aw_hold_nxt  = aw_hold;
    case (aw_state)
      AW_RUN: begin
        if (|AWGRANT && !hs_aw) begin
          aw_state_nxt = AW_WAIT;
          aw_hold_nxt  = AWGRANT;
        end
      end
      AW_WAIT: begin
        if (hs_aw) aw_state_nxt = AW_RUN;
      end
      default: aw_state_nxt = AW_RUN;
    endcase
  end

  always_ff @(posedge AXI_CLK or negedge AXI_RSTn) begin
    if (!AXI_RSTn) begin
      aw_state <= AW_RUN;
      aw_hold  <= '0;
    end else begin
      aw_state <= aw_state_nxt;
      aw_hold  <= aw_hold_nxt;
    end
  end

  // ---------------- AR channel ----------------
  always_comb begin
    ARGRANT = '0;
    if (AXI_RSTn) begin
      case (ar_state)
        AR_RUN:  ARGRANT = ar_sel;
        AR_WAIT: ARGRANT = ar_hold;
        default: ARGRANT = '0;
      endcase
    end
  end

  assign hs_ar = |(ARGRANT & ARVALID & ARREADY);

  always_comb begin
    ar_state_nxt = ar_state;
    ar_hold_nxt  = ar_hold;
    case (ar_state)
      AR_RUN: begin
        if (|ARGRANT && !hs_ar) begin
          ar_state_nxt = AR_WAIT;
          ar_hold_nxt  = ARGRANT;
        end
      end
      AR_WAIT: begin
        if (hs_ar) ar_state_nxt = AR_RUN;
      end
      default: ar_state_nxt = AR_RUN;
    endcase
  end

  always_ff @(posedge AXI_CLK or negedge AXI_RSTn) begin
    if (!AXI_RSTn) begin
      ar_state <= AR_RUN;
      ar_hold  <= '0;
    end else begin
      ar_state <= ar_state_nxt;
      ar_hold  <= ar_hold_nxt;
    end
  end

  assign aw_state_dbg = aw_state;
  assign ar_state_dbg = ar_state;

  // ---------------- AW-order FIFO ----------------
  // Pointers carry one extra wrap bit: equal means empty, differing only in
  // the wrap bit means full.
  always_comb begin
    aw_idx = '0;
    for (int i = 0; i <= NUM; i++) begin
      if (AWGRANT[i]) aw_idx = IW'(i);
    end
  end

  assign wfifo_empty = (wr_ptr == rd_ptr);
  assign wfifo_full  = (wr_ptr[LW] != rd_ptr[LW]) &&
                       (wr_ptr[LW-1:0] == rd_ptr[LW-1:0]);
  assign wfifo_level = wr_ptr - rd_ptr;
  assign wf_head     = wf_mem[rd_ptr[LW-1:0]];

  always_comb begin
    WGRANT = '0;
    if (AXI_RSTn && !wfifo_empty) begin
      for (int i = 0; i <= NUM; i++) begin
        if (wf_head == IW'(i)) WGRANT[i] = 1'b1;
      end
    end
  end

  assign w_pop = |(WGRANT & WVALID & WREADY & WLAST);

  always_ff @(posedge AXI_CLK or negedge AXI_RSTn) begin
    if (!AXI_RSTn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (hs_aw) wr_ptr <= wr_ptr + 1'b1;
      if (w_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge AXI_CLK) begin
    if (hs_aw) wf_mem[wr_ptr[LW-1:0]] <= aw_idx;
  end

endmodule
